// File: rtl/hdq_poll_sequencer.sv
// Periodic HDQ gauge poller: sweeps REG_LIST as lo/hi byte reads through hdq_interface
// and keeps a result file of assembled 16-bit words with per-entry valid bits.
module hdq_poll_sequencer #(
    parameter int                    NUM_REGS       = 4,
    parameter logic [8*NUM_REGS-1:0] REG_LIST       = {8'h2C, 8'h14, 8'h08, 8'h06},
    parameter int                    POLL_INTERVAL  = 50_000_000,
    parameter int                    TIMEOUT_CYCLES = 5_000_000,
    parameter int                    GAP_CYCLES     = 10_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                poll_now,
    output logic                hdq_start,
    output logic [7:0]          hdq_addr,
    input  logic                hdq_done,
    input  logic [7:0]          hdq_data,
    input  logic [2:0]          rd_idx,
    output logic [15:0]         rd_data,
    output logic [NUM_REGS-1:0] valid,
    output logic                word_valid,
    output logic [2:0]          word_idx,
    output logic [15:0]         word_data,
    output logic                busy,
    output logic                sweep_done,
    output logic                err_timeout
);

    localparam int         PW       = $clog2(POLL_INTERVAL + 1);
    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_STORE = 3'd4
    } state_t;

    function automatic logic [7:0] reg_cmd(input logic [2:0] i);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i == 3'(k)) begin
                c = REG_LIST[8*k +: 8];
            end
        end
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                byte_hi_q, byte_hi_d;
    logic [7:0]          lo_q, lo_d, hi_q, hi_d;
    logic                timed_out_q, timed_out_d;
    logic                abort_q, abort_d;
    logic                pending_q, pending_d;
    logic                enable_q, enable_d;
    logic                done_q, done_d;
    logic [PW-1:0]       poll_cnt_q, poll_cnt_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                hdq_start_q, hdq_start_d;
    logic [7:0]          hdq_addr_q, hdq_addr_d;
    logic [15:0]         mem_q [NUM_REGS];
    logic [15:0]         mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] valid_q, valid_d;
    logic                word_valid_q, word_valid_d;
    logic [2:0]          word_idx_q, word_idx_d;
    logic [15:0]         word_data_q, word_data_d;
    logic                busy_q, busy_d;
    logic                sweep_done_q, sweep_done_d;
    logic                err_timeout_q, err_timeout_d;

    logic                done_edge_s;
    logic                trigger_s;
    logic                advance_s;
    logic [7:0]          sum_s;

    // Next-state, datapath and output computation
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        byte_hi_d     = byte_hi_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        timed_out_d   = timed_out_q;
        abort_d       = abort_q;
        pending_d     = pending_q;
        enable_d      = enable;
        done_d        = hdq_done;
        poll_cnt_d    = poll_cnt_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        hdq_start_d   = hdq_start_q;
        hdq_addr_d    = hdq_addr_q;
        mem_d         = mem_q;
        valid_d       = valid_q;
        word_valid_d  = 1'b0;
        word_idx_d    = word_idx_q;
        word_data_d   = word_data_q;
        busy_d        = busy_q;
        sweep_done_d  = 1'b0;
        err_timeout_d = 1'b0;
        advance_s     = 1'b0;
        done_edge_s   = hdq_done & ~done_q;
        trigger_s     = poll_now | pending_q |
                        (enable & (poll_cnt_q == PW'(POLL_INTERVAL - 1)));
        sum_s         = reg_cmd(idx_q) + {7'b0000000, byte_hi_q};

        // Only a falling enable aborts, so a poll_now sweep run with enable=0 completes
        if (state_q != S_IDLE) begin
            if (enable_q && !enable) begin
                abort_d = 1'b1;
            end else begin
                abort_d = abort_q;
            end
            if (poll_now) begin
                pending_d = 1'b1;
            end else begin
                pending_d = pending_q;
            end
        end else begin
            abort_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (trigger_s) begin
                    state_d     = S_ISSUE;
                    idx_d       = 3'd0;
                    byte_hi_d   = 1'b0;
                    timed_out_d = 1'b0;
                    pending_d   = 1'b0;
                    poll_cnt_d  = '0;
                    busy_d      = 1'b1;
                end else if (enable) begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                end else begin
                    poll_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                hdq_addr_d  = sum_s & 8'h7F;
                hdq_start_d = 1'b1;
                to_cnt_d    = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // Done wins over a timeout landing on the same cycle
                if (done_edge_s) begin
                    if (byte_hi_q) begin
                        hi_d = hdq_data;
                    end else begin
                        lo_d = hdq_data;
                    end
                    hdq_start_d = 1'b0;
                    gap_cnt_d   = '0;
                    state_d     = S_GAP;
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    hdq_start_d   = 1'b0;
                    err_timeout_d = 1'b1;
                    timed_out_d   = 1'b1;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (idx_q == 3'(k)) begin
                            valid_d[k] = 1'b0;
                        end
                    end
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    if (abort_q) begin
                        abort_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (timed_out_q) begin
                        advance_s = 1'b1;
                    end else if (!byte_hi_q) begin
                        byte_hi_d = 1'b1;
                        state_d   = S_ISSUE;
                    end else begin
                        // Word is written whole here so the file never holds half a reading
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (idx_q == 3'(k)) begin
                                mem_d[k]   = {hi_q, lo_q};
                                valid_d[k] = 1'b1;
                            end
                        end
                        word_valid_d = 1'b1;
                        word_idx_d   = idx_q;
                        word_data_d  = {hi_q, lo_q};
                        state_d      = S_STORE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_STORE: begin
                advance_s = 1'b1;
            end
            default: begin
                hdq_start_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        if (advance_s) begin
            byte_hi_d   = 1'b0;
            timed_out_d = 1'b0;
            if (idx_q == LAST_IDX) begin
                sweep_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end else begin
                idx_d   = idx_q + 3'd1;
                state_d = S_ISSUE;
            end
        end else begin
            byte_hi_d = byte_hi_d;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 3'd0;
            byte_hi_q     <= 1'b0;
            lo_q          <= 8'h00;
            hi_q          <= 8'h00;
            timed_out_q   <= 1'b0;
            abort_q       <= 1'b0;
            pending_q     <= 1'b0;
            enable_q      <= 1'b0;
            done_q        <= 1'b0;
            poll_cnt_q    <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            hdq_start_q   <= 1'b0;
            hdq_addr_q    <= 8'h00;
            for (int k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= 16'h0000;
            end
            valid_q       <= '0;
            word_valid_q  <= 1'b0;
            word_idx_q    <= 3'd0;
            word_data_q   <= 16'h0000;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            byte_hi_q     <= byte_hi_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            timed_out_q   <= timed_out_d;
            abort_q       <= abort_d;
            pending_q     <= pending_d;
            enable_q      <= enable_d;
            done_q        <= done_d;
            poll_cnt_q    <= poll_cnt_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            hdq_start_q   <= hdq_start_d;
            hdq_addr_q    <= hdq_addr_d;
            mem_q         <= mem_d;
            valid_q       <= valid_d;
            word_valid_q  <= word_valid_d;
            word_idx_q    <= word_idx_d;
            word_data_q   <= word_data_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Result file read port; out-of-range indices read as zero
    always_comb begin
        rd_data = 16'h0000;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == 3'(k)) begin
                rd_data = mem_q[k];
            end
        end
    end

    assign hdq_start   = hdq_start_q;
    assign hdq_addr    = hdq_addr_q;
    assign valid       = valid_q;
    assign word_valid  = word_valid_q;
    assign word_idx    = word_idx_q;
    assign word_data   = word_data_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_hdq_poll_sequencer.sv
// Directed bench for hdq_poll_sequencer with a simple HDQ responder model
// (done 50 cycles after start, data = addr ^ 8'hA5).
module tb_hdq_poll_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        poll_now;
    logic        hdq_start;
    logic [7:0]  hdq_addr;
    logic        hdq_done;
    logic [7:0]  hdq_data;
    logic [2:0]  rd_idx;
    logic [15:0] rd_data;
    logic [3:0]  valid;
    logic        word_valid;
    logic [2:0]  word_idx;
    logic [15:0] word_data;
    logic        busy;
    logic        sweep_done;
    logic        err_timeout;

    logic        model_off, silent_en, mdl_done, man_done;
    logic [7:0]  mdl_data, man_data;
    int          mcnt;
    logic        prev_start;

    logic [7:0]  addr_log [$];
    logic [2:0]  widx_log [$];
    logic [15:0] wdata_log [$];
    int          sweep_cnt, err_cnt, start08_cycles;

    int          n_pass, n_total;
    int          base_a, base_w, base_s, base_e, base_08;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t     rd_tab [7];
    logic [7:0]  exp_addr [8];
    logic [7:0]  exp_to_addr [7];

    assign hdq_done = model_off ? man_done : mdl_done;
    assign hdq_data = model_off ? man_data : mdl_data;

    hdq_poll_sequencer #(
        .NUM_REGS      (4),
        .REG_LIST      ({8'h2C, 8'h14, 8'h08, 8'h06}),
        .POLL_INTERVAL (1000),
        .TIMEOUT_CYCLES(500),
        .GAP_CYCLES    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .poll_now   (poll_now),
        .hdq_start  (hdq_start),
        .hdq_addr   (hdq_addr),
        .hdq_done   (hdq_done),
        .hdq_data   (hdq_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .valid      (valid),
        .word_valid (word_valid),
        .word_idx   (word_idx),
        .word_data  (word_data),
        .busy       (busy),
        .sweep_done (sweep_done),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Responder model and event monitor, both on the falling edge
    initial begin
        mdl_done = 1'b0; mdl_data = 8'h00; mcnt = 0; prev_start = 1'b0;
        sweep_cnt = 0; err_cnt = 0; start08_cycles = 0;
        forever begin
            @(negedge clk);
            if (hdq_start && !prev_start) addr_log.push_back(hdq_addr);
            if (hdq_start && hdq_addr == 8'h08) start08_cycles++;
            if (word_valid) begin
                widx_log.push_back(word_idx);
                wdata_log.push_back(word_data);
            end
            if (sweep_done) sweep_cnt++;
            if (err_timeout) err_cnt++;
            prev_start = hdq_start;
            if (hdq_start) begin
                if (mcnt < 50) mcnt++;
                if (mcnt == 50 && !(silent_en && (hdq_addr == 8'h08 || hdq_addr == 8'h09))) begin
                    mdl_done = 1'b1;
                    mdl_data = hdq_addr ^ 8'hA5;
                end
            end else begin
                mcnt = 0;
                mdl_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pulse_poll();
        @(negedge clk); poll_now = 1'b1;
        @(negedge clk); poll_now = 1'b0;
    endtask

    task automatic wait_sweep(input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sweep_done) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_start(input logic [7:0] a, input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (hdq_start && hdq_addr == a) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic snapshot();
        base_a = addr_log.size(); base_w = widx_log.size();
        base_s = sweep_cnt; base_e = err_cnt; base_08 = start08_cycles;
    endtask

    initial begin
        int lat;
        logic seen;
        n_pass = 0; n_total = 0;
        rd_tab[0] = '{3'd0, 16'hA2A3};
        rd_tab[1] = '{3'd1, 16'hACAD};
        rd_tab[2] = '{3'd2, 16'hB0B1};
        rd_tab[3] = '{3'd3, 16'h8889};
        rd_tab[4] = '{3'd4, 16'h0000};
        rd_tab[5] = '{3'd5, 16'h0000};
        rd_tab[6] = '{3'd7, 16'h0000};
        exp_addr    = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h14, 8'h15, 8'h2C, 8'h2D};
        exp_to_addr = '{8'h06, 8'h07, 8'h08, 8'h14, 8'h15, 8'h2C, 8'h2D};

        rst = 1'b0; enable = 1'b1; poll_now = 1'b0; rd_idx = 3'd0;
        model_off = 1'b0; silent_en = 1'b0; man_done = 1'b0; man_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdq_start", {31'd0, hdq_start}, 32'd0);
        check("rst_hdq_addr", {24'd0, hdq_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {28'd0, valid}, 32'd0);
        check("rst_pulses", {29'd0, sweep_done, word_valid, err_timeout}, 32'd0);
        rst = 1'b1;

        // Automatic sweep with enable=1
        snapshot();
        wait_sweep(3000, "sweep1_done");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        check("sweep1_addr_count", addr_log.size() - base_a, 32'd8);
        for (int i = 0; i < 8; i++)
            if (base_a + i < addr_log.size())
                check($sformatf("sweep1_addr%0d", i), {24'd0, addr_log[base_a + i]}, {24'd0, exp_addr[i]});
        check("sweep1_word_count", widx_log.size() - base_w, 32'd4);
        if (base_w + 1 < widx_log.size()) begin
            check("word0_idx", {29'd0, widx_log[base_w]}, 32'd0);
            check("word0_data", {16'd0, wdata_log[base_w]}, 32'hA2A3);
            check("word1_idx", {29'd0, widx_log[base_w + 1]}, 32'd1);
            check("word1_data", {16'd0, wdata_log[base_w + 1]}, 32'hACAD);
        end
        check("sweep1_valid", {28'd0, valid}, 32'hF);
        check("sweep1_done_count", sweep_cnt - base_s, 32'd1);
        check("sweep1_no_timeout", err_cnt - base_e, 32'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rd_idx = rd_tab[i].idx;
            #1;
            check($sformatf("rd_data_idx%0d", rd_tab[i].idx), {16'd0, rd_data}, {16'd0, rd_tab[i].exp});
        end
        rd_idx = 3'd0;

        // Timeout on register 08, poll_now with enable=0
        silent_en = 1'b1;
        snapshot();
        pulse_poll();
        wait_sweep(3000, "to_sweep_done");
        repeat (3) @(negedge clk);
        silent_en = 1'b0;
        check("to_addr_count", addr_log.size() - base_a, 32'd7);
        for (int i = 0; i < 7; i++)
            if (base_a + i < addr_log.size())
                check($sformatf("to_addr%0d", i), {24'd0, addr_log[base_a + i]}, {24'd0, exp_to_addr[i]});
        check("to_err_count", err_cnt - base_e, 32'd1);
        check("to_valid", {28'd0, valid}, 32'b1101);
        check("to_start_high_cycles", start08_cycles - base_08, 32'd500);
        repeat (1100) @(negedge clk);
        check("no_auto_sweep_enable0", sweep_cnt - base_s, 32'd1);
        check("no_auto_issue_enable0", addr_log.size() - base_a, 32'd7);

        // poll_now twice while busy collapses to one restart
        snapshot();
        pulse_poll();
        repeat (100) @(negedge clk);
        pulse_poll();
        repeat (100) @(negedge clk);
        pulse_poll();
        wait_sweep(3000, "pend_sweep1_done");
        @(negedge clk);
        check("pend_restart_busy", {31'd0, busy}, 32'd1);
        wait_sweep(3000, "pend_sweep2_done");
        repeat (1100) @(negedge clk);
        check("pend_sweep_count", sweep_cnt - base_s, 32'd2);
        check("pend_addr_count", addr_log.size() - base_a, 32'd16);

        // enable falls during the WAIT for 14
        snapshot();
        enable = 1'b1;
        pulse_poll();
        wait_start(8'h14, 2000, "abort_reach_14");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle(2000, "abort_idle");
        repeat (3) @(negedge clk);
        check("abort_no_sweep_done", sweep_cnt - base_s, 32'd0);
        check("abort_addr_count", addr_log.size() - base_a, 32'd5);
        check("abort_word_count", widx_log.size() - base_w, 32'd2);
        rd_idx = 3'd2;
        #1;
        check("abort_entry2_kept", {16'd0, rd_data}, 32'hB0B1);
        rd_idx = 3'd0;

        // Reset during WAIT, then automatic start latency
        enable = 1'b1;
        pulse_poll();
        wait_start(8'h06, 100, "rst_reach_wait");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_hdq_start", {31'd0, hdq_start}, 32'd0);
        check("midrst_valid", {28'd0, valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rd_data", {16'd0, rd_data}, 32'd0);
        rst = 1'b1;
        lat = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (busy) begin lat = i; break; end
        end
        check("auto_start_latency", lat, 32'd1000);
        enable = 1'b0;
        wait_idle(2000, "post_rst_abort_idle");

        // done held high on entry to WAIT needs a fresh edge
        snapshot();
        model_off = 1'b1;
        man_done = 1'b1;
        pulse_poll();
        wait_start(8'h06, 100, "held_reach_06");
        repeat (30) @(negedge clk);
        check("held_no_capture", {31'd0, hdq_start}, 32'd1);
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        man_data = 8'h5A; man_done = 1'b1;
        repeat (2) @(negedge clk);
        check("fresh_edge_capture", {31'd0, hdq_start}, 32'd0);
        wait_start(8'h07, 100, "held_reach_07");
        repeat (5) @(negedge clk);
        check("held_hi_no_capture", {31'd0, hdq_start}, 32'd1);
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        man_data = 8'h3C; man_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (word_valid) begin seen = 1'b1; break; end
        end
        check("held_word_seen", {31'd0, seen}, 32'd1);
        check("held_word_idx", {29'd0, word_idx}, 32'd0);
        check("held_word_data", {16'd0, word_data}, 32'h3C5A);
        man_done = 1'b0;
        model_off = 1'b0;
        wait_sweep(2000, "held_sweep_done");
        repeat (2) @(negedge clk);
        rd_idx = 3'd0;
        #1;
        check("held_rd_entry0", {16'd0, rd_data}, 32'h3C5A);
        check("held_valid", {28'd0, valid}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hdq_poll_sequencer.md
Name: hdq_poll_sequencer

Overview:
- Command-side sequencer that drives hdq_interface and consumes its byte results.
- Periodically sweeps a fixed list of 16-bit gauge registers. Each register is read as two HDQ byte reads: low byte at cmd, high byte at cmd+1.
- Assembles the 16-bit words and stores them in a small result file with per-entry valid bits.
- Reports timeouts so host logic sees a coherent snapshot of gauge state.

Parameters:
NUM_REGS, 4, number of 16-bit registers per sweep (1..8)
REG_LIST, {8'h2C,8'h14,8'h08,8'h06}, packed 8-bit command codes; entry i at bits [8i+7:8i]; bit7 of each code must be 0 (read)
POLL_INTERVAL, 50_000_000, clk cycles between automatic sweep starts (1 s at 50 MHz)
TIMEOUT_CYCLES, 5_000_000, max cycles from hdq_start assert to hdq_done rising edge
GAP_CYCLES, 10_000, idle cycles between consecutive byte transactions (HDQ bus recovery)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-low
enable  in  1  1 = automatic polling runs; 0 = no new sweeps
poll_now  in  1  single-cycle request for an immediate sweep
hdq_start  out  1  start level to hdq_interface
hdq_addr  out  8  command byte to hdq_interface; bit7 always 0
hdq_done  in  1  done from hdq_interface; a 0->1 edge marks completion
hdq_data  in  8  data_out from hdq_interface; sampled on the done edge cycle
rd_idx  in  3  result file read index
rd_data  out  16  combinational: entry rd_idx, or 0 if rd_idx >= NUM_REGS
valid  out  NUM_REGS  per-entry valid bits
word_valid  out  1  one-cycle pulse when a word is stored
word_idx  out  3  index of the stored word; qualified by word_valid
word_data  out  16  {hi,lo} of the stored word; qualified by word_valid
busy  out  1  high while a sweep is in progress
sweep_done  out  1  one-cycle pulse at sweep end
err_timeout  out  1  one-cycle pulse on a transaction timeout

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. hdq_start=0, hdq_addr=0, valid=0, result file=0, all pulses 0, busy=0, timers=0, pending flag=0.
- Interval timer: counts only while enable=1 and in IDLE. It reloads to 0 when a sweep starts or when enable=0.
- Sweep trigger: timer==POLL_INTERVAL-1, or poll_now=1, or pending=1.
- poll_now while busy: sets pending. The sweep restarts on the cycle after sweep_done. Multiple requests collapse into one.
- poll_now is honoured even when enable=0.
- States:
  - IDLE: on trigger -> ISSUE with idx=0, byte_sel=LO. busy=1 from the next cycle.
  - ISSUE: hdq_addr = REG_LIST[idx] + byte_sel (8-bit add, wraps), hdq_start=1, timeout counter cleared -> WAIT.
  - WAIT: hdq_start held at 1.
    - hdq_done rising edge: capture hdq_data into lo or hi, hdq_start=0 -> GAP.
    - Counter reaches TIMEOUT_CYCLES-1 first: hdq_start=0, err_timeout pulse, valid[idx] cleared, remaining byte of this register skipped -> GAP with idx advance.
  - GAP: wait GAP_CYCLES with hdq_start=0.
    - If byte_sel=LO and no timeout: byte_sel=HI -> ISSUE.
    - If a HI byte was captured: -> STORE.
    - If a timeout occurred: advance idx.
  - STORE: mem[idx]={hi,lo}, valid[idx]=1. word_valid, word_idx and word_data are asserted for exactly this cycle. Advance idx.
  - Advance: idx==NUM_REGS-1 -> sweep_done pulse, busy=0, -> IDLE. Otherwise idx+1, byte_sel=LO -> ISSUE.
- Done edge detection uses a registered copy of hdq_done. A level already high when entering WAIT is not a completion; a fresh 0->1 edge is required.
- enable 1->0 mid-sweep: the current byte transaction and its GAP complete. The sweep then aborts to IDLE with sweep_done=0. Entries already stored keep their values.
- Reset mid-transaction: hdq_start drops at that edge; the partial word is discarded.
- The result file is never partially updated: lo and hi are written together in STORE only.
- A timeout and a done edge on the same cycle count as done.

Test Plan:
- Params POLL_INTERVAL=1000, TIMEOUT_CYCLES=500, GAP_CYCLES=20; enable=1; the model answers each start with done after 50 cycles, data = addr ^ 8'hA5. Expect hdq_addr sequence 06,07,08,09,14,15,2C,2D. Word 0 = 16'hA2A3, word 1 = 16'hACAD. valid=4'hF; one sweep_done.
- The model never raises done for addr 08/09. Expect hdq_start to drop 500 cycles after issuing 08, one err_timeout, no 09 issued, valid=4'b1101, and the sweep continues at 14.
- poll_now pulsed twice during a sweep -> exactly one extra sweep starts 1 cycle after sweep_done. With enable=0, a poll_now in IDLE starts one sweep.
- enable dropped during the WAIT for addr 14 -> the 14 byte completes, then GAP, then IDLE. 15 is never issued; entry 2 is not stored; sweep_done stays 0.
- rst=0 asserted during WAIT -> hdq_start=0 and valid=0 at the next edge. After release, no sweep starts before 1000 cycles (enable=1).
- hdq_done held high while entering WAIT -> no capture until it falls and rises again. rd_idx=5 returns 16'h0000.
